// File: rtl/freq_calc.sv
// Frequency calculator: rounds sig_cnt * REF_FREQ_HZ / ref_cnt to whole Hz using a
// sequential shift-add multiplier and a restoring divider, then strobes the result.
module freq_calc #(
    parameter logic [31:0] REF_FREQ_HZ = 32'd100_000_000
) (
    input  logic        clk_200M,
    input  logic        rst_n,
    input  logic [31:0] sig_cnt,
    input  logic [31:0] ref_cnt,
    input  logic        start,
    output logic        busy,
    output logic        freq_valid,
    output logic [31:0] freq_hz,
    output logic        ovf,
    output logic        div_err,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] d_q, d_d;
    logic [31:0] last_sig_q, last_sig_d;
    logic [31:0] last_ref_q, last_ref_d;
    logic [63:0] mcand_q, mcand_d;
    // acc holds the product, then the numerator being shifted out while quotient bits shift in
    logic [63:0] acc_q, acc_d;
    logic [63:0] rem_q, rem_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [31:0] hz_q, hz_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;

    logic        trig;
    logic [64:0] rem_shift;
    logic [64:0] rem_sub;
    logic        rem_ge;
    logic [63:0] mul_add;
    logic [63:0] round_add;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        d_d        = d_q;
        last_sig_d = last_sig_q;
        last_ref_d = last_ref_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        hz_d       = hz_q;
        ovf_d      = ovf_q;
        err_d      = err_q;

        trig      = start | (sig_cnt != last_sig_q) | (ref_cnt != last_ref_q);
        mul_add   = a_q[0] ? mcand_q : 64'd0;
        round_add = (cnt_q == 6'd31) ? {33'd0, d_q[31:1]} : 64'd0;

        // Remainder stays below d (< 2^32), so bit 64 of the difference is a clean borrow.
        rem_shift = {rem_q, acc_q[63]};
        rem_sub   = rem_shift - {33'd0, d_q};
        rem_ge    = ~rem_sub[64];

        case (state_q)
            S_IDLE: begin
                if (trig) begin
                    a_d        = sig_cnt;
                    d_d        = ref_cnt;
                    last_sig_d = sig_cnt;
                    last_ref_d = ref_cnt;
                    acc_d      = 64'd0;
                    mcand_d    = {32'd0, REF_FREQ_HZ};
                    cnt_d      = 6'd0;
                    busy_d     = 1'b1;
                    state_d    = S_MUL;
                end
            end
            S_MUL: begin
                acc_d   = acc_q + mul_add + round_add;
                a_d     = a_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = 6'd0;
                    rem_d   = 64'd0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = rem_ge ? rem_sub[63:0] : rem_shift[63:0];
                acc_d = {acc_q[62:0], rem_ge};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (d_q == 32'd0) begin
                    hz_d  = 32'd0;
                    ovf_d = 1'b0;
                    err_d = 1'b1;
                end else if (acc_q[63:32] != 32'd0) begin
                    hz_d  = 32'hFFFF_FFFF;
                    ovf_d = 1'b1;
                    err_d = 1'b0;
                end else begin
                    hz_d  = acc_q[31:0];
                    ovf_d = 1'b0;
                    err_d = 1'b0;
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            a_q        <= 32'd0;
            d_q        <= 32'd0;
            last_sig_q <= 32'd0;
            last_ref_q <= 32'd0;
            mcand_q    <= 64'd0;
            acc_q      <= 64'd0;
            rem_q      <= 64'd0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            hz_q       <= 32'd0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            d_q        <= d_d;
            last_sig_q <= last_sig_d;
            last_ref_q <= last_ref_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            hz_q       <= hz_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign busy        = busy_q;
    assign freq_valid  = valid_q;
    assign freq_hz     = hz_q;
    assign ovf         = ovf_q;
    assign div_err     = err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_freq_calc.sv
// Directed bench for freq_calc: vector table for the arithmetic plus hand-written
// sequences for reset, mid-flight input changes and reset during a computation.
module tb_freq_calc;

    localparam logic [31:0] REF = 32'd100_000_000;

    logic        clk_200M = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] sig_cnt  = 32'd0;
    logic [31:0] ref_cnt  = 32'd0;
    logic        start    = 1'b0;
    logic        busy;
    logic        freq_valid;
    logic [31:0] freq_hz;
    logic        ovf;
    logic        div_err;
    logic [1:0]  state_dbg_o;

    freq_calc #(.REF_FREQ_HZ(REF)) dut (
        .clk_200M    (clk_200M),
        .rst_n       (rst_n),
        .sig_cnt     (sig_cnt),
        .ref_cnt     (ref_cnt),
        .start       (start),
        .busy        (busy),
        .freq_valid  (freq_valid),
        .freq_hz     (freq_hz),
        .ovf         (ovf),
        .div_err     (div_err),
        .state_dbg_o (state_dbg_o)
    );

    always #5 clk_200M = ~clk_200M;

    typedef struct {
        logic [31:0] sig;
        logic [31:0] refc;
        logic [31:0] hz;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t        vecs[6];
    logic [33:0] exp_q[$];   // {ovf, div_err, freq_hz}
    int          n_cmp = 0;
    int          n_err = 0;
    int          nstrobe;
    int          t_first;
    int          t_second;
    logic [33:0] e_mid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_200M);
        #1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] r, input logic st,
                          input logic [33:0] exp, input string name);
        @(negedge clk_200M);
        sig_cnt = s;
        ref_cnt = r;
        start   = st;
        exp_q.push_back(exp);
        tick();
        start = 1'b0;
        check({name, "_busy_rise"}, 64'(busy), 64'd1);
        check({name, "_state_mul"}, 64'(state_dbg_o), 64'd1);
    endtask

    task automatic wait_strobe(input string name, input int exp_lat);
        int          k;
        logic        seen;
        logic [33:0] e;
        k    = 0;
        seen = 1'b0;
        e    = '0;
        while (!seen && k < 200) begin
            tick();
            k++;
            if (freq_valid) seen = 1'b1;
        end
        check({name, "_strobe"}, 64'(seen), 64'd1);
        if (seen) begin
            check({name, "_latency"}, 64'(k), 64'(exp_lat));
            check({name, "_busy_low"}, 64'(busy), 64'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({name, "_hz"}, 64'(freq_hz), 64'(e[31:0]));
                check({name, "_ovf"}, 64'(ovf), 64'(e[33]));
                check({name, "_div_err"}, 64'(div_err), 64'(e[32]));
            end else begin
                n_cmp++;
                n_err++;
                $display("FAIL %s_scoreboard: got unexpected strobe expected none", name);
            end
            tick();
            check({name, "_one_cycle"}, 64'(freq_valid), 64'd0);
            check({name, "_hz_hold"}, 64'(freq_hz), 64'(e[31:0]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sig: 32'd1000,    refc: 32'd100_000_000, hz: 32'd1000,        ovf: 1'b0, err: 1'b0};
        vecs[1] = '{sig: 32'd3,       refc: 32'd199_999_999, hz: 32'd2,           ovf: 1'b0, err: 1'b0};
        vecs[2] = '{sig: 32'd3,       refc: 32'd200_000_001, hz: 32'd1,           ovf: 1'b0, err: 1'b0};
        vecs[3] = '{sig: 32'd100_000, refc: 32'd1,           hz: 32'hFFFF_FFFF,   ovf: 1'b1, err: 1'b0};
        vecs[4] = '{sig: 32'd2,       refc: 32'd2,           hz: 32'd100_000_000, ovf: 1'b0, err: 1'b0};
        vecs[5] = '{sig: 32'd5,       refc: 32'd0,           hz: 32'd0,           ovf: 1'b0, err: 1'b1};

        // Reset state
        repeat (3) @(posedge clk_200M);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(freq_valid), 64'd0);
        check("rst_hz", 64'(freq_hz), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_div_err", 64'(div_err), 64'd0);
        check("rst_state", 64'(state_dbg_o), 64'd0);

        // 0/0 after release matches last=0 and must not start anything
        @(negedge clk_200M);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("zero_no_trig", 64'(busy), 64'd0);
        end

        // Only start forces the 0/0 computation
        launch(32'd0, 32'd0, 1'b1, {1'b0, 1'b1, 32'd0}, "start_zero");
        wait_strobe("start_zero", 97);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].sig, vecs[i].refc, 1'b0, {vecs[i].ovf, vecs[i].err, vecs[i].hz}, $sformatf("vec%0d", i));
            wait_strobe($sformatf("vec%0d", i), 97);
        end

        // Unchanged inputs: only start recomputes
        launch(32'd5, 32'd0, 1'b1, {1'b0, 1'b1, 32'd0}, "restart");
        wait_strobe("restart", 97);

        // Mid-flight change plus start: exactly two strobes, second one back-to-back
        launch(32'd1000, REF, 1'b0, {2'b00, 32'd1000}, "mid");
        repeat (39) tick();
        @(negedge clk_200M);
        sig_cnt = 32'd2000;
        start   = 1'b1;
        exp_q.push_back({2'b00, 32'd2000});
        @(negedge clk_200M);
        start    = 1'b0;
        nstrobe  = 0;
        t_first  = -1;
        t_second = -1;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (t_first >= 0 && t == t_first + 1)
                check("mid_busy_after_strobe", 64'(busy), 64'd1);
            if (freq_valid) begin
                nstrobe++;
                if (nstrobe == 1) t_first = t;
                else if (nstrobe == 2) t_second = t;
                if (exp_q.size() > 0) begin
                    e_mid = exp_q.pop_front();
                    check("mid_hz", 64'(freq_hz), 64'(e_mid[31:0]));
                end
            end
        end
        check("mid_strobe_count", 64'(nstrobe), 64'd2);
        check("mid_first_time", 64'(t_first), 64'd57);
        check("mid_second_time", 64'(t_second), 64'd155);

        // Reset in the middle of a computation
        launch(32'd1000, REF, 1'b0, {2'b00, 32'd1000}, "abort");
        repeat (49) tick();
        @(negedge clk_200M);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hz", 64'(freq_hz), 64'd0);
        check("abort_state", 64'(state_dbg_o), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("abort_no_strobe", 64'(freq_valid), 64'd0);
        end
        @(negedge clk_200M);
        rst_n = 1'b1;
        exp_q.push_back({2'b00, 32'd1000});
        tick();
        check("post_reset_busy", 64'(busy), 64'd1);
        wait_strobe("post_reset", 97);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
